// File: rtl/line_seq_pkg.sv
// line_seq_pkg: shared widths, screen size, segment record and sequencer state for line_sequencer
package line_seq_pkg;
  localparam int COORD_W = 13;
  localparam int COLOR_W = 3;
  localparam int ADDR_W = 19;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef struct packed {
    logic [COORD_W-1:0] startX;
    logic [COORD_W-1:0] startY;
    logic [COORD_W-1:0] endX;
    logic [COORD_W-1:0] endY;
    logic [COLOR_W-1:0] color;
    logic last;
  } seg_t;
  typedef enum logic [2:0] {IDLE, LOAD, START, DRAW, FRAME} state_t;
  function automatic logic clipOut(input logic signed [COORD_W-1:0] a, b, lim);
    return (a[COORD_W-1] && b[COORD_W-1]) || (a >= lim && b >= lim);
  endfunction
endpackage

// File: rtl/line_sequencer_fifo.sv
// seg_fifo: DEPTH-entry synchronous FIFO of segment records with occupancy, full and empty
module seg_fifo import line_seq_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  seg_t din,
  output seg_t dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  seg_t mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign dout = mem[rdPtr];
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
endmodule

// File: rtl/line_sequencer.sv
// line_sequencer: queues line segments, issues them to the rasterizer and forwards its pixels; LINE_SEQ_CLIP_REJECT_EN enables trivial off-screen rejection
module line_sequencer import line_seq_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic seg_valid,
  output logic seg_ready,
  input  logic [COORD_W-1:0] seg_startX,
  input  logic [COORD_W-1:0] seg_startY,
  input  logic [COORD_W-1:0] seg_endX,
  input  logic [COORD_W-1:0] seg_endY,
  input  logic [COLOR_W-1:0] seg_color,
  input  logic seg_last,
  output logic [COORD_W-1:0] startX,
  output logic [COORD_W-1:0] startY,
  output logic [COORD_W-1:0] endX,
  output logic [COORD_W-1:0] endY,
  output logic readyIn,
  input  logic done,
  input  logic goodPixel,
  input  logic [ADDR_W-1:0] addressOut,
  output logic px_we,
  output logic [ADDR_W-1:0] px_addr,
  output logic [COLOR_W-1:0] px_color,
  output logic busy,
  output logic frame_done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0] rej_count
);
  state_t state;
  seg_t cur, head;
  logic full, empty, pop, reject;
  assign seg_ready = !rst && !full;
  assign pop = state == IDLE && !empty;
  assign busy = state != IDLE || !empty;
`ifdef LINE_SEQ_CLIP_REJECT_EN
  assign reject = clipOut(cur.startX, cur.endX, COORD_W'(SCREEN_W)) ||
                  clipOut(cur.startY, cur.endY, COORD_W'(SCREEN_H));
`else
  assign reject = 1'b0;
`endif
  seg_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(seg_valid && seg_ready), .pop(pop),
    .din({seg_startX, seg_startY, seg_endX, seg_endY, seg_color, seg_last}),
    .dout(head), .count(fifo_count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      {startX, startY, endX, endY} <= '0;
      readyIn <= 1'b0;
      px_we <= 1'b0;
      px_addr <= '0;
      px_color <= '0;
      frame_done <= 1'b0;
      rej_count <= '0;
    end else begin
      readyIn <= 1'b0;
      frame_done <= 1'b0;
      px_we <= goodPixel && state == DRAW;
      if (goodPixel && state == DRAW) begin
        px_addr <= addressOut;
        px_color <= cur.color;
      end
      case (state)
        IDLE: if (!empty) begin
          cur <= head;
          state <= LOAD;
        end
        LOAD: begin
          {startX, startY, endX, endY} <= {cur.startX, cur.startY, cur.endX, cur.endY};
          if (reject) begin
            rej_count <= rej_count + 16'd1;
            frame_done <= cur.last;
            state <= cur.last ? FRAME : IDLE;
          end else begin
            readyIn <= 1'b1;
            state <= START;
          end
        end
        START: state <= DRAW;
        DRAW: if (done) begin
          frame_done <= cur.last;
          state <= cur.last ? FRAME : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: directed bench with a queue model of issued segments and a pixel/frame checker
module tb_line_sequencer;
  import line_seq_pkg::*;
`ifdef LINE_SEQ_CLIP_REJECT_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef struct {int sx; int sy; int ex; int ey; int c; bit l;} tseg_t;
  logic clk = 0, rst = 1;
  logic seg_valid = 0, seg_ready, seg_last = 0;
  logic [COORD_W-1:0] seg_startX = 0, seg_startY = 0, seg_endX = 0, seg_endY = 0;
  logic [COORD_W-1:0] startX, startY, endX, endY;
  logic [COLOR_W-1:0] seg_color = 0, px_color;
  logic readyIn, done = 0, goodPixel = 0, px_we, busy, frame_done;
  logic [ADDR_W-1:0] addressOut = 0, px_addr;
  logic [3:0] fifo_count;
  logic [15:0] rej_count;
  int nChecks = 0, nFail = 0, cyc = 0;
  int rdyCount = 0, fdCount = 0, pxCount = 0, gpCount = 0;
  int pushCyc = 0, rdyCyc = 0, doneCyc = 0, fdCyc = 0;
  int drawLen = 6, curColor = 0;
  bit autoDone = 1, run = 0, curLast = 0, prevRdy = 0;
  tseg_t modelQ[$];

  line_sequencer dut (
    .clk(clk), .rst(rst), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_startX(seg_startX), .seg_startY(seg_startY), .seg_endX(seg_endX), .seg_endY(seg_endY),
    .seg_color(seg_color), .seg_last(seg_last), .startX(startX), .startY(startY),
    .endX(endX), .endY(endY), .readyIn(readyIn), .done(done), .goodPixel(goodPixel),
    .addressOut(addressOut), .px_we(px_we), .px_addr(px_addr), .px_color(px_color),
    .busy(busy), .frame_done(frame_done), .fifo_count(fifo_count), .rej_count(rej_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic tseg_t mk(input int sx, sy, ex, ey, c, input bit l);
    tseg_t s;
    s.sx = sx; s.sy = sy; s.ex = ex; s.ey = ey; s.c = c; s.l = l;
    return s;
  endfunction

  function automatic bit rejected(input tseg_t s);
    return CLIP && ((s.sx < 0 && s.ex < 0) || (s.sx >= 640 && s.ex >= 640) ||
                    (s.sy < 0 && s.ey < 0) || (s.sy >= 480 && s.ey >= 480));
  endfunction

  task automatic drive(input tseg_t s);
    seg_valid = 1;
    seg_startX = COORD_W'(s.sx); seg_startY = COORD_W'(s.sy);
    seg_endX = COORD_W'(s.ex); seg_endY = COORD_W'(s.ey);
    seg_color = COLOR_W'(s.c); seg_last = s.l;
    pushCyc = cyc;
  endtask

  task automatic pushTry(input tseg_t s, output bit acc);
    @(negedge clk);
    drive(s);
    acc = seg_ready;
    if (acc) modelQ.push_back(s);
    @(posedge clk); #1 seg_valid = 0;
  endtask

  task automatic waitFd(input int target, input int budget);
    for (int i = 0; i < budget && fdCount < target; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("frame_done_timeout", int'(fdCount >= target), 1);
  endtask

  // Rasterizer stand-in: after readyIn, emits drawLen beats with a gap pattern; done rides the final beat.
  initial forever begin
    @(negedge clk);
    if (readyIn && autoDone && !rst) begin
      for (int i = 0; i < drawLen; i++) begin
        @(negedge clk);
        if (rst) break;
        goodPixel = (i % 3) != 1;
        addressOut = ADDR_W'($urandom_range(0, 307199));
        done = i == drawLen - 1;
        if (done) doneCyc = cyc;
        if (goodPixel) gpCount++;
      end
      @(negedge clk);
      goodPixel = 0; done = 0;
    end
  end

  // Checker: issued operands follow push order, pixels appear one cycle later, frames end on last segments.
  initial forever begin
    bit expFd;
    tseg_t s;
    @(posedge clk); #1;
    if (run && !rst) begin
      if (readyIn) begin
        rdyCount++; rdyCyc = cyc;
        check("readyIn_one_cycle", int'(prevRdy), 0);
        while (modelQ.size() > 0 && rejected(modelQ[0]) && !modelQ[0].l) void'(modelQ.pop_front());
        check("readyIn_has_segment", int'(modelQ.size() > 0), 1);
        if (modelQ.size() > 0) begin
          s = modelQ.pop_front();
          check("startX", int'($signed(startX)), s.sx);
          check("startY", int'($signed(startY)), s.sy);
          check("endX", int'($signed(endX)), s.ex);
          check("endY", int'($signed(endY)), s.ey);
          curColor = s.c; curLast = s.l;
        end
      end
      prevRdy = readyIn;
      expFd = done && curLast;
      if (frame_done && !expFd && modelQ.size() > 0 && rejected(modelQ[0]) && modelQ[0].l) begin
        expFd = 1;
        void'(modelQ.pop_front());
      end
      check("frame_done", int'(frame_done), int'(expFd));
      if (frame_done) begin fdCount++; fdCyc = cyc; end
      check("px_we", int'(px_we), int'(goodPixel));
      if (px_we && goodPixel) begin
        pxCount++;
        check("px_addr", int'(px_addr), int'(addressOut));
        check("px_color", int'(px_color), curColor);
      end
      check("seg_ready_vs_full", int'(seg_ready), int'(fifo_count != 4'd8));
    end
  end

  initial begin
    bit acc;
    int r0, f0, p0, g0, nAcc;
    repeat (3) @(posedge clk); #1;
    check("rst_seg_ready", int'(seg_ready), 0);
    check("rst_readyIn", int'(readyIn), 0);
    check("rst_px_we", int'(px_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_rej_count", int'(rej_count), 0);
    check("rst_startX", int'(startX), 0);
    @(negedge clk); rst = 0; #1;
    check("seg_ready_after_rst", int'(seg_ready), 1);
    run = 1;

    // single last segment: latency, pixel count, frame pulse
    r0 = rdyCount; f0 = fdCount; p0 = pxCount; g0 = gpCount;
    pushTry(mk(-25, 50, 75, 250, 5, 1), acc);
    check("t1_accepted", int'(acc), 1);
    waitFd(f0 + 1, 60);
    check("t1_push_to_readyIn", rdyCyc - pushCyc, 3);
    check("t1_done_to_frame", fdCyc - doneCyc, 1);
    check("t1_readyIn_pulses", rdyCount - r0, 1);
    check("t1_frames", fdCount - f0, 1);
    check("t1_pixels_seen", gpCount - g0, 4);
    check("t1_px_we_count", pxCount - p0, gpCount - g0);
    check("t1_idle_busy", int'(busy), 0);

    // back-pressure: one segment drawing, eight queued, next held
    autoDone = 0; drawLen = 4; nAcc = 0; f0 = fdCount;
    for (int i = 0; i < 10; i++) begin
      pushTry(mk(i, 2 * i, i + 10, 3 * i, i % 8, 0), acc);
      nAcc += int'(acc);
    end
    check("t2_accepted", nAcc, 9);
    check("t2_tenth_held", int'(acc), 0);
    check("t2_fifo_count", int'(fifo_count), 8);
    check("t2_seg_ready", int'(seg_ready), 0);
    check("t2_busy", int'(busy), 1);
    @(negedge clk); done = 1;
    @(negedge clk); done = 0; autoDone = 1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) pushTry(mk(9, 18, 19, 27, 1, 1), acc);
    check("t2_tenth_accepted_after_pop", int'(acc), 1);
    waitFd(f0 + 1, 400);
    check("t2_queue_drained", modelQ.size(), 0);

    // three segments, only the third ends the frame
    r0 = rdyCount; f0 = fdCount; drawLen = 3;
    pushTry(mk(0, 0, 0, 0, 2, 0), acc);
    pushTry(mk(-4095, 4095, 639, 479, 3, 0), acc);
    pushTry(mk(100, -100, 200, 300, 6, 1), acc);
    waitFd(f0 + 1, 100);
    check("t3_readyIn_pulses", rdyCount - r0, 3);
    check("t3_frames", fdCount - f0, 1);

    // reset in the middle of a draw
    drawLen = 20; f0 = fdCount; r0 = rdyCount;
    pushTry(mk(1, 1, 30, 30, 4, 1), acc);
    pushTry(mk(2, 2, 40, 40, 7, 0), acc);
    for (int i = 0; i < 50 && rdyCount == r0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    check("t4_readyIn", int'(readyIn), 0);
    check("t4_px_we", int'(px_we), 0);
    check("t4_px_addr", int'(px_addr), 0);
    check("t4_frame_done", int'(frame_done), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_fifo_count", int'(fifo_count), 0);
    check("t4_seg_ready", int'(seg_ready), 0);
    check("t4_startX", int'(startX), 0);
    modelQ.delete(); curLast = 0; prevRdy = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (15) @(posedge clk); #1;
    check("t4_no_frame_after_rst", fdCount - f0, 0);
    check("t4_idle_after_rst", int'(busy), 0);

    // wholly off-screen segment
    drawLen = 3; f0 = fdCount; r0 = rdyCount;
    pushTry(mk(700, 10, 800, 20, 3, 1), acc);
    waitFd(f0 + 1, 60);
    check("t5_readyIn_pulses", rdyCount - r0, CLIP ? 0 : 1);
    check("t5_rej_count", int'(rej_count), CLIP ? 1 : 0);
    check("t5_frames", fdCount - f0, 1);

    // simultaneous push and pop at occupancy 3
    autoDone = 0; f0 = fdCount;
    pushTry(mk(10, 10, 20, 20, 1, 0), acc);
    pushTry(mk(11, 11, 21, 21, 2, 0), acc);
    pushTry(mk(12, 12, 22, 22, 3, 0), acc);
    pushTry(mk(13, 13, 23, 23, 4, 0), acc);
    repeat (2) @(posedge clk); #1;
    check("t6_count_before", int'(fifo_count), 3);
    @(negedge clk); done = 1;
    @(negedge clk); done = 0; autoDone = 1;
    drive(mk(14, 14, 24, 24, 7, 1));
    modelQ.push_back(mk(14, 14, 24, 24, 7, 1));
    @(posedge clk); #1 seg_valid = 0;
    check("t6_count_after_push_pop", int'(fifo_count), 3);
    waitFd(f0 + 1, 200);
    check("t6_queue_drained", modelQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
